// File: rtl/cpu_pkg.sv
// Shared MIPS branch decode constants and the branch result record.
package cpu_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  typedef struct packed {
    logic valid;
    logic taken;
    logic link;
    logic pred;
  } br_result_t;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count up on inc, hold once all-ones is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch condition resolver: decodes the conditional-branch set, optionally
// registers the result, flags mispredicts and keeps retirement statistics.
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [5:0]       opcode,
  input  logic [4:0]       rt_field,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             pred_taken,
  output logic             out_valid,
  output logic             taken,
  output logic             link,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic       w_neg;
  logic       w_zero;
  logic       w_eq;
  logic       w_rec;
  logic       w_cond;
  logic       w_lnk;
  br_result_t w_res;
  br_result_t w_out;
  logic       w_retire;

  assign w_neg  = rs_data[WIDTH-1];
  assign w_zero = (rs_data == '0);
  assign w_eq   = (rs_data == rt_data);

  // Decode opcode / REGIMM rt field into recognised, condition and link.
  always_comb begin
    w_rec  = 1'b0;
    w_cond = 1'b0;
    w_lnk  = 1'b0;
    unique case (opcode)
      OP_BEQ:  begin w_rec = 1'b1; w_cond = w_eq;              end
      OP_BNE:  begin w_rec = 1'b1; w_cond = !w_eq;             end
      OP_BLEZ: begin w_rec = 1'b1; w_cond = w_neg || w_zero;   end
      OP_BGTZ: begin w_rec = 1'b1; w_cond = !w_neg && !w_zero; end
      OP_REGIMM: begin
        unique case (rt_field)
          RT_BLTZ:   begin w_rec = 1'b1; w_cond = w_neg;                 end
          RT_BGEZ:   begin w_rec = 1'b1; w_cond = !w_neg;                end
          RT_BLTZAL: begin w_rec = 1'b1; w_cond = w_neg;  w_lnk = 1'b1;  end
          RT_BGEZAL: begin w_rec = 1'b1; w_cond = !w_neg; w_lnk = 1'b1;  end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  // Taken/link are qualified by valid so an idle or unrecognised slot is all-zero.
  always_comb begin
    w_res.valid = in_valid && w_rec;
    w_res.taken = w_res.valid && w_cond;
    w_res.link  = w_res.valid && w_lnk;
    w_res.pred  = pred_taken;
  end

  generate
    if (PIPE != 0) begin : g_pipe
      br_result_t r_res;

      // Output stage: reset, then flush (beats stall), then stall-hold, else capture.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_res <= '0;
        end else if (flush) begin
          r_res <= '0;
        end else if (!stall) begin
          r_res <= w_res;
        end
      end

      assign w_out = r_res;
    end else begin : g_comb
      assign w_out = w_res;
    end
  endgenerate

  assign out_valid  = w_out.valid;
  assign taken      = w_out.taken;
  assign link       = w_out.link;
  assign mispredict = w_out.valid && (w_out.taken != w_out.pred);

  // A stalled result retires only in the cycle stall drops, so it counts once.
  assign w_retire = out_valid && !stall && !flush;

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_retire),
    .count (br_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_retire && taken),
    .count (taken_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_retire && mispredict),
    .count (mispred_count)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: a PIPE=1/CNT_W=16 unit and a PIPE=0/CNT_W=4 unit share stimulus.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, pred_taken;
  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [31:0] rs_data, rt_data;

  logic        p_valid, p_taken, p_link, p_mp;
  logic [15:0] p_br, p_tk, p_mpc;
  logic        c_valid, c_taken, c_link, c_mp;
  logic [3:0]  c_br, c_tk, c_mpc;

  int checks   = 0;
  int failures = 0;
  int m0_br = 0, m0_tk = 0, m0_mp = 0;
  int m1_br = 0, m1_tk = 0, m1_mp = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .PIPE(1), .CNT_W(16)) u_pipe (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .opcode(opcode), .rt_field(rt_field), .rs_data(rs_data), .rt_data(rt_data),
    .pred_taken(pred_taken), .out_valid(p_valid), .taken(p_taken), .link(p_link),
    .mispredict(p_mp), .br_count(p_br), .taken_count(p_tk), .mispred_count(p_mpc)
  );

  branch_resolve_unit #(.WIDTH(32), .PIPE(0), .CNT_W(4)) u_comb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .opcode(opcode), .rt_field(rt_field), .rs_data(rs_data), .rt_data(rt_data),
    .pred_taken(pred_taken), .out_valid(c_valid), .taken(c_taken), .link(c_link),
    .mispredict(c_mp), .br_count(c_br), .taken_count(c_tk), .mispred_count(c_mpc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int s4(input int x);
    return (x >= 15) ? 15 : x + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "/c.br"}, 32'(c_br),  32'(m0_br));
    chk({tag, "/c.tk"}, 32'(c_tk),  32'(m0_tk));
    chk({tag, "/c.mp"}, 32'(c_mpc), 32'(m0_mp));
    chk({tag, "/p.br"}, 32'(p_br),  32'(m1_br));
    chk({tag, "/p.tk"}, 32'(p_tk),  32'(m1_tk));
    chk({tag, "/p.mp"}, 32'(p_mpc), 32'(m1_mp));
  endtask

  // One branch through both units; pipe must be idle on entry, idle again on exit.
  task automatic br(input string tag, input logic [5:0] op, input logic [4:0] rtf,
                    input logic [31:0] rs, input logic [31:0] rtv, input logic pr,
                    input logic ev, input logic et, input logic el);
    logic em;
    em = ev && (et != pr);
    opcode = op; rt_field = rtf; rs_data = rs; rt_data = rtv; pred_taken = pr;
    in_valid = 1'b1;
    #1;
    chk({tag, "/c.valid"}, 32'(c_valid), 32'(ev));
    chk({tag, "/c.taken"}, 32'(c_taken), 32'(et));
    chk({tag, "/c.link"},  32'(c_link),  32'(el));
    chk({tag, "/c.mp"},    32'(c_mp),    32'(em));
    chk({tag, "/p.lat0"},  32'(p_valid), 32'd0);
    step();
    in_valid = 1'b0;
    if (ev) begin
      m0_br = s4(m0_br);
      if (et) m0_tk = s4(m0_tk);
      if (em) m0_mp = s4(m0_mp);
    end
    chk({tag, "/p.valid"}, 32'(p_valid), 32'(ev));
    chk({tag, "/p.taken"}, 32'(p_taken), 32'(et));
    chk({tag, "/p.link"},  32'(p_link),  32'(el));
    chk({tag, "/p.mp"},    32'(p_mp),    32'(em));
    step();
    if (ev) begin
      m1_br++;
      if (et) m1_tk++;
      if (em) m1_mp++;
    end
    chk({tag, "/p.drain"}, 32'(p_valid), 32'd0);
  endtask

  localparam logic [5:0] OPR = 6'h01, OPEQ = 6'h04, OPNE = 6'h05, OPLE = 6'h06, OPGT = 6'h07;

  logic [31:0] sweep_rs [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};
  logic [4:0]  exp_blez = 5'b00111;  // bit i <-> sweep_rs[i]
  logic [4:0]  exp_bgtz = 5'b11000;
  logic [4:0]  exp_bltz = 5'b00011;
  logic [4:0]  exp_bgez = 5'b11100;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; pred_taken = 1'b0;
    opcode = '0; rt_field = '0; rs_data = '0; rt_data = '0;
    step(); step();
    chk("rst/p.valid", 32'(p_valid), 32'd0);
    chk("rst/p.taken", 32'(p_taken), 32'd0);
    chk("rst/p.link",  32'(p_link),  32'd0);
    chk("rst/p.mp",    32'(p_mp),    32'd0);
    chk_counts("rst");
    reset = 1'b0;
    step();

    // beq / bne
    br("beq_eq", OPEQ, 5'h00, 32'h1234, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b0);
    br("bne_eq", OPNE, 5'h00, 32'h1234, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
    br("beq_ne", OPEQ, 5'h00, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    br("bne_ne", OPNE, 5'h00, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);

    // signed sweep
    for (int i = 0; i < 5; i++) begin
      br($sformatf("blez%0d", i), OPLE, 5'h00, sweep_rs[i], 32'h0, 1'b0, 1'b1, exp_blez[i], 1'b0);
      br($sformatf("bgtz%0d", i), OPGT, 5'h00, sweep_rs[i], 32'h0, 1'b0, 1'b1, exp_bgtz[i], 1'b0);
      br($sformatf("bltz%0d", i), OPR,  5'h00, sweep_rs[i], 32'h0, 1'b0, 1'b1, exp_bltz[i], 1'b0);
      br($sformatf("bgez%0d", i), OPR,  5'h01, sweep_rs[i], 32'h0, 1'b0, 1'b1, exp_bgez[i], 1'b0);
    end
    br("bgezal", OPR, 5'h11, 32'd5, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    br("bltzal", OPR, 5'h10, 32'd5, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    br("regimm_bad", OPR, 5'h02, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    br("op_bad", 6'h02, 5'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_counts("sweep");

    // mispredict: taken beq predicted not-taken
    begin
      int mp0, tk0;
      mp0 = m1_mp; tk0 = m1_tk;
      br("mispred", OPEQ, 5'h00, 32'd9, 32'd9, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("mispred/p.mpc_delta", 32'(p_mpc), 32'(mp0 + 1));
      chk("mispred/p.tk_delta",  32'(p_tk),  32'(tk0 + 1));
    end

    // stall for 3 cycles holds the result and defers its count
    opcode = OPEQ; rt_field = '0; rs_data = 32'd7; rt_data = 32'd7; pred_taken = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    m0_br = s4(m0_br); m0_tk = s4(m0_tk);
    chk("stall/p.valid0", 32'(p_valid), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d/p.valid", i), 32'(p_valid), 32'd1);
      chk($sformatf("stall%0d/p.taken", i), 32'(p_taken), 32'd1);
      chk($sformatf("stall%0d/p.br", i),    32'(p_br),    32'(m1_br));
    end
    stall = 1'b0;
    step();
    m1_br++; m1_tk++;
    chk("stall_rel/p.valid", 32'(p_valid), 32'd0);
    chk_counts("stall_rel");

    // stall and flush together kill the held result, no count
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    m0_br = s4(m0_br); m0_tk = s4(m0_tk);
    chk("sflush/p.valid0", 32'(p_valid), 32'd1);
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    chk("sflush/p.valid", 32'(p_valid), 32'd0);
    chk_counts("sflush");

    // flush with incoming instruction: dropped, not counted anywhere
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_in/p.valid", 32'(p_valid), 32'd0);
    chk_counts("flush_in");
    step();

    // saturation on the CNT_W=4 unit
    reset = 1'b1;
    step();
    reset = 1'b0;
    m0_br = 0; m0_tk = 0; m0_mp = 0; m1_br = 0; m1_tk = 0; m1_mp = 0;
    for (int i = 0; i < 20; i++)
      br($sformatf("sat%0d", i), OPEQ, 5'h00, 32'd3, 32'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat/c.br", 32'(c_br), 32'd15);
    chk("sat/c.tk", 32'(c_tk), 32'd15);
    chk("sat/p.br", 32'(p_br), 32'd20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m0_br = 0; m0_tk = 0; m0_mp = 0; m1_br = 0; m1_tk = 0; m1_mp = 0;
    chk_counts("sat_rst");

    // reset in the same cycle as in_valid
    br("pre_rst", OPEQ, 5'h00, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    opcode = OPEQ; rs_data = 32'd1; rt_data = 32'd1; pred_taken = 1'b0;
    in_valid = 1'b1; reset = 1'b1; stall = 1'b1;
    step();
    in_valid = 1'b0; reset = 1'b0; stall = 1'b0;
    m0_br = 0; m0_tk = 0; m0_mp = 0; m1_br = 0; m1_tk = 0; m1_mp = 0;
    chk("rst_mid/p.valid", 32'(p_valid), 32'd0);
    chk("rst_mid/p.mp",    32'(p_mp),    32'd0);
    chk_counts("rst_mid");
    step();
    chk_counts("rst_mid2");
    br("post_rst", OPR, 5'h01, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_counts("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch-condition resolver for the MIPS pipeline; successor to the combinational branch comparator.
- Evaluates the full conditional-branch set, including the REGIMM rt-encoded forms and the link variants, with correct signed semantics.
- Adds an optional result register with stall/flush, predicted-vs-actual mispredict detection, and saturating branch statistics counters.
- Sits between ID-stage operand forwarding and the PC-select / flush logic.

Parameters:
- WIDTH, 32, operand width in bits.
- PIPE, 1, 0 = combinational result; 1 = one registered stage.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode valid this cycle.
- stall  in  1  hold the output stage; no new capture, no counting.
- flush  in  1  kill the instruction in the output stage.
- opcode  in  6  instruction bits [31:26].
- rt_field  in  5  instruction bits [20:16]; selects the REGIMM variant.
- rs_data  in  WIDTH  forwarded rs operand.
- rt_data  in  WIDTH  forwarded rt operand.
- pred_taken  in  1  prediction made at fetch.
- out_valid  out  1  a recognised branch result is present.
- taken  out  1  branch condition true.
- link  out  1  bltzal/bgezal; write PC+8 to r31, regardless of taken.
- mispredict  out  1  out_valid and (taken != pred_taken).
- br_count  out  CNT_W  resolved branches.
- taken_count  out  CNT_W  resolved taken branches.
- mispred_count  out  CNT_W  resolved mispredicts.

Behaviour:
- Decode. All comparisons are signed two's complement on WIDTH bits.
  - 0x04 beq: rs == rt.
  - 0x05 bne: rs != rt.
  - 0x06 blez: rs[MSB] = 1 or rs == 0.
  - 0x07 bgtz: rs[MSB] = 0 and rs != 0.
  - 0x01 with rt_field 0x00 bltz, 0x10 bltzal: rs[MSB] = 1.
  - 0x01 with rt_field 0x01 bgez, 0x11 bgezal: rs[MSB] = 0.
  - link = 1 only for 0x10 and 0x11.
- Any other opcode/rt_field combination is unrecognised: result valid = 0, taken = 0, link = 0.
- PIPE=0:
  - Outputs are combinational from the inputs; out_valid = in_valid and recognised.
  - stall and flush gate counting only.
- PIPE=1:
  - Latency is 1 cycle. Registers capture {valid, taken, link, pred_taken} each clock edge unless stall is high.
  - flush has priority over stall: the valid register clears to 0 even while stalled.
  - flush and a new in_valid in the same cycle: flush wins; the incoming instruction is dropped (upstream is being squashed).
  - stall held for N cycles: outputs are frozen and identical for N cycles.
- Reset (synchronous): out_valid, taken, link, mispredict and all counters = 0.
  - Reset asserted mid-stall or mid-flush overrides everything.
  - One cycle after reset deasserts, the unit accepts input normally.
- Counters:
  - Each counter increments once per retired result: out_valid = 1, stall = 0, flush = 0.
  - br_count +1 always on retirement; taken_count +1 if taken; mispred_count +1 if mispredict.
  - Counters saturate at all-ones and never wrap.
  - A result held under stall is counted exactly once, in the cycle stall drops.
- mispredict is purely derived from the output-stage values; it is never asserted when out_valid = 0.

Decomposition:
- Shared package (cpu_pkg), constants:
  - OP_REGIMM = 6'h01, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07.
  - RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11.
- Package typedef: br_result_t {valid, taken, link, pred}.
- One sub-module, sat_counter (parameter CNT_W; ports clk, reset, inc, count), instantiated three times.
- Condition decode and the pipeline stage stay inline.

Test Plan:
- beq / bne: WIDTH=32, rs = rt = 0x1234 → beq taken=1, bne taken=0. rs = 0x80000000, rt = 0 → beq 0, bne 1. With PIPE=1, out_valid appears exactly 1 cycle after in_valid.
- Signed sweep, rs ∈ {0x80000000, 0xFFFFFFFF, 0, 1, 0x7FFFFFFF} → taken results:
  - blez = {1, 1, 1, 0, 0}
  - bgtz = {0, 0, 0, 1, 1}
  - bltz = {1, 1, 0, 0, 0}
  - bgez = {0, 0, 1, 1, 1}
  - bgezal rs = 5 → taken=1, link=1; bltzal rs = 5 → taken=0, link=1.
  - opcode 0x01, rt_field 0x02 → out_valid=0.
- Stall/flush: branch accepted, then stall for 3 cycles → outputs constant and br_count unchanged until stall drops, then +1. Stall and flush together → out_valid = 0 next cycle, no count.
- Mispredict: pred_taken=0 on a taken beq → mispredict=1 for one cycle; mispred_count 0 → 1; taken_count 0 → 1.
- Saturation: CNT_W=4, retire 20 taken branches → br_count = taken_count = 15. Assert reset → all counters 0 one cycle later.
- Reset mid-operation: reset asserted in the same cycle as in_valid with PIPE=1 → out_valid = 0 next cycle, no counter change.
